// File: rtl/execute_lsu_unit_pkg.sv
// rtl/execute_lsu_unit_pkg.sv - shared pipeline pack types, widths and size encodings for the LSU
package execute_lsu_unit_pkg;

  localparam int ADDR_WIDTH          = 32;
  localparam int BUS_DATA_WIDTH      = 32;
  localparam int REG_DATA_WIDTH      = 32;
  localparam int ROB_ID_WIDTH        = 7;
  localparam int SIZE_WIDTH          = 2;
  localparam int PHY_REG_ID_WIDTH    = 6;
  localparam int CHECKPOINT_ID_WIDTH = 3;
  localparam int CSR_ADDR_WIDTH      = 12;

  localparam logic [SIZE_WIDTH-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_WIDTH-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_WIDTH-1:0] SIZE_WORD = 2'b10;

  typedef enum logic [3:0] {
    instruction_address_misaligned = 4'd0,
    instruction_access_fault       = 4'd1,
    illegal_instruction            = 4'd2,
    breakpoint                     = 4'd3,
    load_address_misaligned        = 4'd4,
    load_access_fault              = 4'd5,
    store_amo_address_misaligned   = 4'd6,
    store_amo_access_fault         = 4'd7,
    env_call_from_u                = 4'd8,
    env_call_from_s                = 4'd9,
    reserved_10                    = 4'd10,
    env_call_from_m                = 4'd11,
    instruction_page_fault         = 4'd12,
    load_page_fault                = 4'd13,
    reserved_14                    = 4'd14,
    store_amo_page_fault           = 4'd15
  } riscv_exception_t;

  typedef enum logic [2:0] {
    op_unit_alu, op_unit_bru, op_unit_csr, op_unit_div, op_unit_lsu, op_unit_mul
  } op_unit_t;

  typedef enum logic [2:0] {
    op_alu, op_branch, op_csr, op_div, op_load, op_store, op_mul, op_other
  } op_t;

  typedef enum logic [2:0] {
    lsu_lb, lsu_lbu, lsu_lh, lsu_lhu, lsu_lw, lsu_sb, lsu_sh, lsu_sw
  } lsu_op_t;

  typedef struct packed {
    logic                           enable;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [ADDR_WIDTH-1:0]          pc;
    logic [REG_DATA_WIDTH-1:0]      imm;
    logic                           has_exception;
    riscv_exception_t               exception_id;
    logic [REG_DATA_WIDTH-1:0]      exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [ADDR_WIDTH-1:0]          predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic [4:0]                     rs1;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [REG_DATA_WIDTH-1:0]      src1_value;
    logic [4:0]                     rs2;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [REG_DATA_WIDTH-1:0]      src2_value;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [CSR_ADDR_WIDTH-1:0]      csr;
    logic [ADDR_WIDTH-1:0]          lsu_addr;
    op_t                            op;
    op_unit_t                       op_unit;
    lsu_op_t                        sub_op;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                           enable;
    logic                           valid;
    logic [ROB_ID_WIDTH-1:0]        rob_id;
    logic [ADDR_WIDTH-1:0]          pc;
    logic [REG_DATA_WIDTH-1:0]      imm;
    logic                           has_exception;
    riscv_exception_t               exception_id;
    logic [REG_DATA_WIDTH-1:0]      exception_value;
    logic                           predicted;
    logic                           predicted_jump;
    logic [ADDR_WIDTH-1:0]          predicted_next_pc;
    logic                           checkpoint_id_valid;
    logic [CHECKPOINT_ID_WIDTH-1:0] checkpoint_id;
    logic [4:0]                     rs1;
    logic [PHY_REG_ID_WIDTH-1:0]    rs1_phy;
    logic [REG_DATA_WIDTH-1:0]      src1_value;
    logic [4:0]                     rs2;
    logic [PHY_REG_ID_WIDTH-1:0]    rs2_phy;
    logic [REG_DATA_WIDTH-1:0]      src2_value;
    logic [4:0]                     rd;
    logic                           rd_enable;
    logic                           need_rename;
    logic [PHY_REG_ID_WIDTH-1:0]    rd_phy;
    logic [REG_DATA_WIDTH-1:0]      rd_value;
    logic [CSR_ADDR_WIDTH-1:0]      csr;
    logic [ADDR_WIDTH-1:0]          lsu_addr;
    op_t                            op;
    op_unit_t                       op_unit;
    lsu_op_t                        sub_op;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [REG_DATA_WIDTH-1:0]   value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic                  enable;
    logic                  has_exception;
    logic [ADDR_WIDTH-1:0] exception_pc;
    logic                  flush;
  } commit_feedback_pack_t;

  function automatic logic [SIZE_WIDTH-1:0] store_size(input lsu_op_t op);
    case (op)
      lsu_sb:  return SIZE_BYTE;
      lsu_sh:  return SIZE_HALF;
      default: return SIZE_WORD;
    endcase
  endfunction

  function automatic logic [BUS_DATA_WIDTH-1:0] store_data(input lsu_op_t op,
                                                           input logic [BUS_DATA_WIDTH-1:0] v);
    case (op)
      lsu_sb:  return {24'b0, v[7:0]};
      lsu_sh:  return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic execute_wb_pack_t to_wb(input issue_execute_pack_t p,
                                             input logic [REG_DATA_WIDTH-1:0] rd_value);
    execute_wb_pack_t w;
    w.enable              = p.enable;
    w.valid               = p.valid;
    w.rob_id              = p.rob_id;
    w.pc                  = p.pc;
    w.imm                 = p.imm;
    w.has_exception       = p.has_exception;
    w.exception_id        = p.exception_id;
    w.exception_value     = p.exception_value;
    w.predicted           = p.predicted;
    w.predicted_jump      = p.predicted_jump;
    w.predicted_next_pc   = p.predicted_next_pc;
    w.checkpoint_id_valid = p.checkpoint_id_valid;
    w.checkpoint_id       = p.checkpoint_id;
    w.rs1                 = p.rs1;
    w.rs1_phy             = p.rs1_phy;
    w.src1_value          = p.src1_value;
    w.rs2                 = p.rs2;
    w.rs2_phy             = p.rs2_phy;
    w.src2_value          = p.src2_value;
    w.rd                  = p.rd;
    w.rd_enable           = p.rd_enable;
    w.need_rename         = p.need_rename;
    w.rd_phy              = p.rd_phy;
    w.rd_value            = rd_value;
    w.csr                 = p.csr;
    w.lsu_addr            = p.lsu_addr;
    w.op                  = p.op;
    w.op_unit             = p.op_unit;
    w.sub_op              = p.sub_op;
    return w;
  endfunction

endpackage

// File: rtl/execute_lsu_unit_load_extend.sv
// rtl/execute_lsu_unit_load_extend.sv - sign/zero extension of right-aligned load data
module lsu_load_extend
  import execute_lsu_unit_pkg::*;
(
  input  lsu_op_t                   lsu_op,
  input  logic [BUS_DATA_WIDTH-1:0] data,
  output logic [REG_DATA_WIDTH-1:0] rd_value
);

  always_comb begin
    rd_value = data;
    case (lsu_op)
      lsu_lb:  rd_value = {{24{data[7]}}, data[7:0]};
      lsu_lbu: rd_value = {24'b0, data[7:0]};
      lsu_lh:  rd_value = {{16{data[15]}}, data[15:0]};
      lsu_lhu: rd_value = {16'b0, data[15:0]};
      default: rd_value = data;
    endcase
  end

endmodule

// File: rtl/execute_lsu_unit.sv
// rtl/execute_lsu_unit.sv - stateless execute-stage load/store unit between issue FIFO and wb port
module execute_lsu_unit
  import execute_lsu_unit_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BUS_DATA_WIDTH-1:0]     stbuf_exlsu_bus_data,
  input  logic [BUS_DATA_WIDTH-1:0]     stbuf_exlsu_bus_data_feedback,
  input  logic                          stbuf_exlsu_bus_ready,
  output logic [ROB_ID_WIDTH-1:0]       exlsu_stbuf_rob_id,
  output logic [ADDR_WIDTH-1:0]         exlsu_stbuf_write_addr,
  output logic [SIZE_WIDTH-1:0]         exlsu_stbuf_write_size,
  output logic [BUS_DATA_WIDTH-1:0]     exlsu_stbuf_write_data,
  output logic                          exlsu_stbuf_push,
  input  logic                          stbuf_exlsu_full,
  input  issue_execute_pack_t           issue_lsu_fifo_data_out,
  input  logic                          issue_lsu_fifo_data_out_valid,
  output logic                          issue_lsu_fifo_pop,
  output execute_wb_pack_t              lsu_wb_port_data_in,
  output logic                          lsu_wb_port_we,
  output logic                          lsu_wb_port_flush,
  output execute_feedback_channel_t     lsu_execute_channel_feedback_pack,
  input  commit_feedback_pack_t         commit_feedback_pack
);

  issue_execute_pack_t       p;
  logic                      flush_req;
  logic                      idle;
  logic                      is_load;
  logic [REG_DATA_WIDTH-1:0] load_value;

  assign p         = issue_lsu_fifo_data_out;
  assign flush_req = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign idle      = !rst || flush_req || !issue_lsu_fifo_data_out_valid;
  assign is_load   = p.sub_op inside {lsu_lb, lsu_lbu, lsu_lh, lsu_lhu, lsu_lw};

  // Clock and raw bus data are part of the port contract only.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, stbuf_exlsu_bus_data,
                           commit_feedback_pack.has_exception, commit_feedback_pack.exception_pc};

  lsu_load_extend u_load_extend (
    .lsu_op   (p.sub_op),
    .data     (stbuf_exlsu_bus_data_feedback),
    .rd_value (load_value)
  );

  // Store buffer fields track the head continuously; push alone qualifies them.
  assign exlsu_stbuf_rob_id     = p.rob_id;
  assign exlsu_stbuf_write_addr = p.lsu_addr;
  assign exlsu_stbuf_write_size = store_size(p.sub_op);
  assign exlsu_stbuf_write_data = store_data(p.sub_op, p.src2_value);

  always_comb begin
    issue_lsu_fifo_pop                = 1'b0;
    lsu_wb_port_we                    = 1'b0;
    lsu_wb_port_flush                 = 1'b1;
    exlsu_stbuf_push                  = 1'b0;
    lsu_execute_channel_feedback_pack = '0;
    lsu_wb_port_data_in               = '0;
    if (!idle) begin
      lsu_wb_port_data_in = to_wb(p, '0);
      if (!p.enable) begin
        issue_lsu_fifo_pop = 1'b1;
      end else if (!p.valid || p.has_exception) begin
        issue_lsu_fifo_pop = 1'b1;
        lsu_wb_port_we     = 1'b1;
        lsu_wb_port_flush  = 1'b0;
      end else if (is_load) begin
        if (stbuf_exlsu_bus_ready) begin
          issue_lsu_fifo_pop           = 1'b1;
          lsu_wb_port_we               = 1'b1;
          lsu_wb_port_flush            = 1'b0;
          lsu_wb_port_data_in.rd_value = load_value;
          if (p.rd_enable && p.need_rename) begin
            lsu_execute_channel_feedback_pack.enable = 1'b1;
            lsu_execute_channel_feedback_pack.phy_id = p.rd_phy;
            lsu_execute_channel_feedback_pack.value  = load_value;
          end
        end
      end else if (!stbuf_exlsu_full) begin
        exlsu_stbuf_push   = 1'b1;
        issue_lsu_fifo_pop = 1'b1;
        lsu_wb_port_we     = 1'b1;
        lsu_wb_port_flush  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_lsu_unit.sv
// tb/tb_execute_lsu_unit.sv - scoreboard bench for execute_lsu_unit with directed vectors
module tb_execute_lsu_unit;
  import execute_lsu_unit_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [31:0]               bus_data;
  logic [31:0]               bus_fb;
  logic                      bus_ready;
  logic [ROB_ID_WIDTH-1:0]   st_rob_id;
  logic [ADDR_WIDTH-1:0]     st_addr;
  logic [SIZE_WIDTH-1:0]     st_size;
  logic [31:0]               st_data;
  logic                      st_push;
  logic                      st_full;
  issue_execute_pack_t       pk;
  logic                      fifo_valid;
  logic                      fifo_pop;
  execute_wb_pack_t          wb;
  logic                      wb_we;
  logic                      wb_flush;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     cf;

  execute_lsu_unit dut (
    .clk                               (clk),
    .rst                               (rst),
    .stbuf_exlsu_bus_data              (bus_data),
    .stbuf_exlsu_bus_data_feedback     (bus_fb),
    .stbuf_exlsu_bus_ready             (bus_ready),
    .exlsu_stbuf_rob_id                (st_rob_id),
    .exlsu_stbuf_write_addr            (st_addr),
    .exlsu_stbuf_write_size            (st_size),
    .exlsu_stbuf_write_data            (st_data),
    .exlsu_stbuf_push                  (st_push),
    .stbuf_exlsu_full                  (st_full),
    .issue_lsu_fifo_data_out           (pk),
    .issue_lsu_fifo_data_out_valid     (fifo_valid),
    .issue_lsu_fifo_pop                (fifo_pop),
    .lsu_wb_port_data_in               (wb),
    .lsu_wb_port_we                    (wb_we),
    .lsu_wb_port_flush                 (wb_flush),
    .lsu_execute_channel_feedback_pack (fb),
    .commit_feedback_pack              (cf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          pop, we, flush, push, fb_en;
    logic [5:0]  fb_phy;
    logic [31:0] fb_val;
    bit          wb_en, wb_valid, wb_exc;
    logic [3:0]  wb_exc_id;
    bit          chk_rd;
    logic [31:0] rd_value;
    logic [6:0]  st_rob;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec %0d %s: got 0x%08h, expected 0x%08h", id, nm, act, exp);
    end
  endtask

  function automatic exp_t ex(input int id, input bit pop, input bit we, input bit fl, input bit push);
    exp_t e;
    e = '{id: id, pop: pop, we: we, flush: fl, push: push, fb_en: 1'b0, fb_phy: '0, fb_val: '0,
          wb_en: 1'b0, wb_valid: 1'b0, wb_exc: 1'b0, wb_exc_id: '0, chk_rd: 1'b1, rd_value: '0,
          st_rob: '0, st_addr: '0, st_size: '0, st_data: '0};
    return e;
  endfunction

  function automatic exp_t with_wb(input exp_t e, input issue_execute_pack_t q);
    exp_t r = e;
    r.wb_en     = q.enable;
    r.wb_valid  = q.valid;
    r.wb_exc    = q.has_exception;
    r.wb_exc_id = q.exception_id;
    return r;
  endfunction

  function automatic exp_t with_fb(input exp_t e, input logic [5:0] phy, input logic [31:0] v);
    exp_t r = e;
    r.fb_en = 1'b1; r.fb_phy = phy; r.fb_val = v; r.rd_value = v;
    return r;
  endfunction

  function automatic exp_t with_st(input exp_t e, input logic [6:0] rob, input logic [31:0] a,
                                   input logic [1:0] s, input logic [31:0] d);
    exp_t r = e;
    r.st_rob = rob; r.st_addr = a; r.st_size = s; r.st_data = d;
    return r;
  endfunction

  function automatic issue_execute_pack_t base_pack(input lsu_op_t op);
    issue_execute_pack_t q = '0;
    q.enable      = 1'b1;
    q.valid       = 1'b1;
    q.rob_id      = 7'd3;
    q.pc          = 32'h8000_0100;
    q.rd          = 5'd5;
    q.rd_enable   = 1'b1;
    q.need_rename = 1'b1;
    q.rd_phy      = 6'd10;
    q.lsu_addr    = 32'h0000_0100;
    q.op_unit     = op_unit_lsu;
    q.sub_op      = op;
    return q;
  endfunction

  // Monitor: one expected response per applied vector, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.id, "pop",       32'(fifo_pop),        32'(e.pop));
      chk(e.id, "we",        32'(wb_we),           32'(e.we));
      chk(e.id, "flush",     32'(wb_flush),        32'(e.flush));
      chk(e.id, "push",      32'(st_push),         32'(e.push));
      chk(e.id, "fb_enable", 32'(fb.enable),       32'(e.fb_en));
      chk(e.id, "wb_enable", 32'(wb.enable),       32'(e.wb_en));
      chk(e.id, "wb_valid",  32'(wb.valid),        32'(e.wb_valid));
      chk(e.id, "wb_exc",    32'(wb.has_exception), 32'(e.wb_exc));
      chk(e.id, "wb_exc_id", 32'(wb.exception_id), 32'(e.wb_exc_id));
      if (e.chk_rd) chk(e.id, "rd_value", wb.rd_value, e.rd_value);
      if (e.fb_en) begin
        chk(e.id, "fb_phy", 32'(fb.phy_id), 32'(e.fb_phy));
        chk(e.id, "fb_val", fb.value, e.fb_val);
      end
      if (e.push) begin
        chk(e.id, "st_rob",  32'(st_rob_id), 32'(e.st_rob));
        chk(e.id, "st_addr", st_addr,        e.st_addr);
        chk(e.id, "st_size", 32'(st_size),   32'(e.st_size));
        chk(e.id, "st_data", st_data,        e.st_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; fifo_valid = 1'b0; pk = base_pack(lsu_lw); bus_data = 32'hffff_ffff;
    bus_fb = '0; bus_ready = 1'b0; st_full = 1'b0; cf = '0;

    // 0: reset with a ready load at the head stays idle
    step(); fifo_valid = 1'b1; bus_fb = 32'hdace_1557; bus_ready = 1'b1;
    sb_q.push_back(ex(0, 0, 0, 1, 0));
    // 1: out of reset, empty FIFO
    step(); rst = 1'b1; fifo_valid = 1'b0;
    sb_q.push_back(ex(1, 0, 0, 1, 0));
    // 2: exception pass-through
    step(); fifo_valid = 1'b1; pk = base_pack(lsu_lw); pk.valid = 1'b0; pk.has_exception = 1'b1;
    pk.exception_id = illegal_instruction; bus_ready = 1'b0;
    sb_q.push_back(with_wb(ex(2, 1, 1, 0, 0), pk));
    // 3: lw
    step(); pk = base_pack(lsu_lw); bus_fb = 32'hdace_1557; bus_ready = 1'b1;
    sb_q.push_back(with_fb(with_wb(ex(3, 1, 1, 0, 0), pk), 6'd10, 32'hdace_1557));
    // 4: lb sign extension
    step(); pk = base_pack(lsu_lb); bus_fb = 32'h0000_0080;
    sb_q.push_back(with_fb(with_wb(ex(4, 1, 1, 0, 0), pk), 6'd10, 32'hffff_ff80));
    // 5: lw stall on bus_ready
    step(); pk = base_pack(lsu_lw); bus_ready = 1'b0;
    e = with_wb(ex(5, 0, 0, 1, 0), pk); e.chk_rd = 1'b0; sb_q.push_back(e);
    // 6: sh stalled by full store buffer
    step(); pk = base_pack(lsu_sh); pk.rob_id = 7'd7; pk.lsu_addr = 32'haacc_beef;
    pk.src2_value = 32'hdead_beef; st_full = 1'b1;
    sb_q.push_back(with_wb(ex(6, 0, 0, 1, 0), pk));
    // 7: sh pushed
    step(); st_full = 1'b0;
    sb_q.push_back(with_st(with_wb(ex(7, 1, 1, 0, 1), pk), 7'd7, 32'haacc_beef, 2'b01, 32'h0000_beef));
    // 8: commit feedback without flush leaves the store alone
    step(); cf.enable = 1'b1; cf.flush = 1'b0;
    sb_q.push_back(with_st(with_wb(ex(8, 1, 1, 0, 1), pk), 7'd7, 32'haacc_beef, 2'b01, 32'h0000_beef));
    // 9: flush overrides the store
    step(); cf.flush = 1'b1;
    sb_q.push_back(ex(9, 0, 0, 1, 0));
    // 10: bubble
    step(); cf = '0; pk = base_pack(lsu_lw); pk.enable = 1'b0; bus_ready = 1'b1;
    sb_q.push_back(with_wb(ex(10, 1, 0, 1, 0), pk));
    // 11-13: remaining extensions
    step(); pk = base_pack(lsu_lhu); bus_fb = 32'h1234_8765;
    sb_q.push_back(with_fb(with_wb(ex(11, 1, 1, 0, 0), pk), 6'd10, 32'h0000_8765));
    step(); pk = base_pack(lsu_lh); pk.rd_phy = 6'd33;
    sb_q.push_back(with_fb(with_wb(ex(12, 1, 1, 0, 0), pk), 6'd33, 32'hffff_8765));
    step(); pk = base_pack(lsu_lbu); bus_fb = 32'hffff_ff80;
    sb_q.push_back(with_fb(with_wb(ex(13, 1, 1, 0, 0), pk), 6'd10, 32'h0000_0080));
    // 14: load without rename gives no feedback
    step(); pk = base_pack(lsu_lw); pk.need_rename = 1'b0; bus_fb = 32'h0000_55aa;
    e = with_wb(ex(14, 1, 1, 0, 0), pk); e.rd_value = 32'h0000_55aa; sb_q.push_back(e);
    // 15-16: misaligned sb / sw pushed unchanged
    step(); pk = base_pack(lsu_sb); pk.rob_id = 7'd100; pk.lsu_addr = 32'h0000_0003;
    pk.src2_value = 32'h1234_5678; bus_ready = 1'b0;
    sb_q.push_back(with_st(with_wb(ex(15, 1, 1, 0, 1), pk), 7'd100, 32'h0000_0003, 2'b00, 32'h0000_0078));
    step(); pk = base_pack(lsu_sw); pk.rob_id = 7'd1; pk.lsu_addr = 32'h0000_0102;
    pk.src2_value = 32'hcafe_f00d;
    sb_q.push_back(with_st(with_wb(ex(16, 1, 1, 0, 1), pk), 7'd1, 32'h0000_0102, 2'b10, 32'hcafe_f00d));
    // 17: flush during a load stall
    step(); pk = base_pack(lsu_lw); cf.enable = 1'b1; cf.flush = 1'b1;
    sb_q.push_back(ex(17, 0, 0, 1, 0));
    // 18: store with exception passes through without a push
    step(); cf = '0; pk = base_pack(lsu_sw); pk.has_exception = 1'b1;
    pk.exception_id = store_amo_address_misaligned; st_full = 1'b1;
    sb_q.push_back(with_wb(ex(18, 1, 1, 0, 0), pk));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses left, expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
